// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared opcodes, FSM state encoding and op-decode helpers for
//               the HI/LO multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int unsigned MDU_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = MDU_WIDTH;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Unsigned radix-2 restoring divider, one quotient bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // The dividend shifts out of quo_q MSB-first while quotient bits fill in
    // from the bottom. Since rem < divisor, the shifted value is < 2*divisor,
    // so bit WIDTH of the difference is a clean borrow flag.
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, dvs_q};
    assign w_fits  = ~w_diff[WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            quo_q <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            quo_q <= {quo_q[WIDTH-2:0], w_fits};
            rem_q <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Execute-stage MULT/MULTU/DIV/DIVU engine producing {hi,lo}
//               with a pipeline stall and a one-cycle result strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH   = MDU_WIDTH,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned        c_CNT_MAX  = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned        c_CNT_W    = $clog2(c_CNT_MAX) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] prod_q;

    logic               w_go, w_latch, w_commit;
    logic               w_src_signed;
    logic [WIDTH-1:0]   w_src_a_mag, w_src_b_mag;
    logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_product;
    logic [WIDTH-1:0]   w_quo, w_rem, w_quo_fix, w_rem_fix, w_div_hi, w_div_lo;
    logic               w_op_signed, w_a_neg, w_b_neg, w_div_by_zero;
    logic [2*WIDTH-1:0] w_res;

    assign w_go = start_i & ~cancel_i;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        valid_o = 1'b0;
        w_latch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = w_go;
                if (w_go) begin
                    w_latch = 1'b1;
                    cnt_d   = '0;
                    state_d = op_is_div(op_i) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                stall_o = ~cancel_i;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_MUL_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                stall_o = ~cancel_i;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // DONE never re-arms: the instruction that just finished may
                // still be presenting start_i while it advances.
                valid_o = ~cancel_i;
                state_d = ST_IDLE;
            end
        endcase
        if (cancel_i) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
        end
    end

    assign busy_o   = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign w_commit = valid_o;

    assign w_mul_a   = op_is_signed(op_q) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign w_mul_b   = op_is_signed(op_q) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign w_product = w_mul_a * w_mul_b;

    // The divider is loaded straight from the issuing operands so that all
    // WIDTH steps fit inside the DIV state.
    assign w_src_signed = op_is_signed(op_i);
    assign w_src_a_mag  = (w_src_signed && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign w_src_b_mag  = (w_src_signed && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (w_latch & op_is_div(op_i)),
        .step_i      (state_q == ST_DIV),
        .dividend_i  (w_src_a_mag),
        .divisor_i   (w_src_b_mag),
        .quotient_o  (w_quo),
        .remainder_o (w_rem)
    );

    assign w_op_signed   = op_is_signed(op_q);
    assign w_a_neg       = w_op_signed & a_q[WIDTH-1];
    assign w_b_neg       = w_op_signed & b_q[WIDTH-1];
    assign w_div_by_zero = (b_q == '0);
    assign w_quo_fix     = (w_a_neg ^ w_b_neg) ? -w_quo : w_quo;
    assign w_rem_fix     = w_a_neg ? -w_rem : w_rem;
    assign w_div_hi      = w_div_by_zero ? a_q : w_rem_fix;
    assign w_div_lo      = w_div_by_zero ? '1  : w_quo_fix;
    assign w_res         = op_is_div(op_q) ? {w_div_hi, w_div_lo} : prod_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            prod_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (w_latch) begin
                op_q <= op_i;
                a_q  <= src_a_i;
                b_q  <= src_b_i;
            end
            if (state_q == ST_MUL) begin
                prod_q <= w_product;
            end
            if (w_commit) begin
                hi_q <= w_res[2*WIDTH-1:WIDTH];
                lo_q <= w_res[WIDTH-1:0];
            end
        end
    end

    // The fresh result is visible during DONE; a cancelled DONE shows the
    // previously committed values instead.
    assign hi_o = w_commit ? w_res[2*WIDTH-1:WIDTH] : hi_q;
    assign lo_o = w_commit ? w_res[WIDTH-1:0]       : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Scoreboard bench for mul_div_unit with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int W  = 32;
    localparam int ML = 2;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic          start_i  = 1'b0;
    logic          cancel_i = 1'b0;
    logic [1:0]    op_i     = 2'b00;
    logic [W-1:0]  src_a_i  = '0;
    logic [W-1:0]  src_b_i  = '0;
    logic          stall_o, busy_o, valid_o;
    logic [W-1:0]  hi_o, lo_o;

    logic [63:0]   exp_q[$];
    logic [63:0]   last_res = 64'd0;
    logic [63:0]   mon_exp;
    int            n_cmp = 0;
    int            n_err = 0;

    mul_div_unit #(
        .WIDTH   (W),
        .MUL_LAT (ML)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .op_i     (op_i),
        .src_a_i  (src_a_i),
        .src_b_i  (src_b_i),
        .cancel_i (cancel_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint p;
        int     q, r;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            OP_MULTU: return 64'(a) * 64'(b);
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (resetn && valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got hi=%h lo=%h expected no result", hi_o, lo_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {hi_o, lo_o}, mon_exp);
                last_res = mon_exp;
            end
        end
    end

    // Issue one op, count the stall cycles, and scramble operands after issue.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        int exp_stall;
        exp_stall = op[1] ? 1 + W : 1 + ML;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        start_i = 1'b1;
        exp_q.push_back(ref_model(op, a, b));
        #1;
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            src_a_i = $urandom();
            src_b_i = $urandom();
            #1;
        end
        check("stall_cycles", 64'(n), 64'(exp_stall));
        check("valid_in_done", 64'(valid_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        int sel;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        #12;
        check("reset_ctrl", 64'({stall_o, busy_o, valid_o}), 64'd0);
        check("reset_hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_op(OP_MULT,  32'hFFFF_FFFE, 32'd3);
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
        do_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2);
        do_op(OP_DIVU,  32'h0000_1234, 32'd0);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        do_op(OP_DIV,   32'h0000_0007, 32'd0);

        // cancel mid-divide at counter 10
        op_i    = OP_DIV;
        src_a_i = 32'd1000;
        src_b_i = 32'd7;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cancel_i = 1'b1;
        #1;
        check("cancel_stall", 64'({stall_o, valid_o}), 64'd0);
        @(posedge clk);
        #1;
        cancel_i = 1'b0;
        #1;
        check("cancel_idle", 64'(busy_o), 64'd0);
        check("cancel_hilo", {hi_o, lo_o}, last_res);
        repeat (40) @(posedge clk);
        #1;
        do_op(OP_MULT, 32'd12345, 32'hFFFF_FF00);

        // start held high across DONE: one result per op, re-issue from IDLE
        op_i    = OP_MULT;
        src_a_i = 32'd77;
        src_b_i = 32'hFFFF_FFF0;
        start_i = 1'b1;
        exp_q.push_back(ref_model(OP_MULT, 32'd77, 32'hFFFF_FFF0));
        exp_q.push_back(ref_model(OP_MULT, 32'd77, 32'hFFFF_FFF0));
        v = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (valid_o) v++;
            @(posedge clk);
        end
        start_i = 1'b0;
        #1;
        check("held_start_valids", 64'(v), 64'd2);
        @(posedge clk);
        #1;

        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom();
            rb  = $urandom();
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 20));
            do_op(rop, ra, rb);
        end

        // asynchronous reset mid-divide
        op_i    = OP_DIV;
        src_a_i = 32'hDEAD_BEEF;
        src_b_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(busy_o), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_reset_ctrl", 64'({stall_o, busy_o, valid_o}), 64'd0);
        check("async_reset_hilo", {hi_o, lo_o}, 64'd0);
        last_res = 64'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        do_op(OP_DIVU, 32'd100, 32'd9);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
